// File: rtl/instr_fetch_buffer.sv
// Instruction queue between fetch and decode: absorbs responses under decoder
// back-pressure, drops wrong-path responses after a redirect, and raises an early stall.
module instr_fetch_buffer #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 1,
    parameter int FLUSH_DROP   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       fetch_valid_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    input  logic [XLEN-1:0]            fetch_instr_i,
    output logic                       fetch_ready_o,
    output logic                       stall_o,
    input  logic                       flush_i,
    output logic                       instr_valid_o,
    output logic [XLEN-1:0]            instr_pc_o,
    output logic [XLEN-1:0]            instr_o,
    output logic                       instr_fault_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W:0] DEPTH_C  = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0] MARGIN_C = (CNT_W+1)'(STALL_MARGIN);
    localparam logic [2:0]     DROP_C   = 3'(FLUSH_DROP);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic             fault_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       drop_cnt_q, drop_cnt_d;

    logic             dropping;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   free_slots;

    assign dropping      = (drop_cnt_q != 3'd0);
    assign fetch_ready_o = (count_q < CNT_W'(DEPTH)) | dropping;
    assign instr_valid_o = (count_q != '0) & ~flush_i;

    assign push = fetch_valid_i & fetch_ready_o & ~flush_i & ~dropping;
    assign pop  = instr_valid_o & instr_ready_i;

    // One extra bit so the subtraction can never wrap for any legal margin.
    assign free_slots = DEPTH_C - {1'b0, count_q};
    assign stall_o    = (free_slots <= MARGIN_C);

    assign instr_pc_o    = pc_q[rd_ptr_q];
    assign instr_o       = instr_q[rd_ptr_q];
    assign instr_fault_o = fault_q[rd_ptr_q];
    assign count_o       = count_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = DROP_C;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (dropping) drop_cnt_d = drop_cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                fault_q[i] <= 1'b0;
            end
        end else if (push) begin
            pc_q[wr_ptr_q]    <= fetch_pc_i;
            instr_q[wr_ptr_q] <= fetch_instr_i;
            fault_q[wr_ptr_q] <= (fetch_pc_i[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (DEPTH=4, STALL_MARGIN=1, FLUSH_DROP=1).
module tb_instr_fetch_buffer;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            fetch_valid_i;
    logic [XLEN-1:0] fetch_pc_i;
    logic [XLEN-1:0] fetch_instr_i;
    logic            fetch_ready_o;
    logic            stall_o;
    logic            flush_i;
    logic            instr_valid_o;
    logic [XLEN-1:0] instr_pc_o;
    logic [XLEN-1:0] instr_o;
    logic            instr_fault_o;
    logic            instr_ready_i;
    logic [2:0]      count_o;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_buffer #(
        .XLEN(XLEN), .DEPTH(4), .STALL_MARGIN(1), .FLUSH_DROP(1)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .fetch_valid_i (fetch_valid_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_ready_o (fetch_ready_o),
        .stall_o       (stall_o),
        .flush_i       (flush_i),
        .instr_valid_o (instr_valid_o),
        .instr_pc_o    (instr_pc_o),
        .instr_o       (instr_o),
        .instr_fault_o (instr_fault_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Apply one cycle's inputs; the instruction word is the inverted PC.
    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic rdy);
        fetch_valid_i = v;
        fetch_pc_i    = pc;
        fetch_instr_i = ~pc;
        flush_i       = fl;
        instr_ready_i = rdy;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_pc_i = '0;
        fetch_instr_i = '0;
        flush_i = 1'b0;
        instr_ready_i = 1'b0;
        #2;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_ready", 32'(fetch_ready_o), 32'd1);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_pc", instr_pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_fault", 32'(instr_fault_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Streaming with decoder always ready: one-cycle latency, count peaks at 1.
        drive(1'b1, 32'h0, 1'b0, 1'b1);
        chk("t1_valid_first", 32'(instr_valid_o), 32'd0);
        cyc();
        drive(1'b1, 32'h4, 1'b0, 1'b1);
        chk("t1_valid", 32'(instr_valid_o), 32'd1);
        chk("t1_pc0", instr_pc_o, 32'h0);
        chk("t1_instr0", instr_o, ~32'h0);
        chk("t1_cnt0", 32'(count_o), 32'd1);
        cyc();
        drive(1'b1, 32'h8, 1'b0, 1'b1);
        chk("t1_pc1", instr_pc_o, 32'h4);
        chk("t1_cnt1", 32'(count_o), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_pc2", instr_pc_o, 32'h8);
        chk("t1_instr2", instr_o, ~32'h8);
        chk("t1_cnt2", 32'(count_o), 32'd1);
        cyc();
        chk("t1_empty_cnt", 32'(count_o), 32'd0);
        chk("t1_empty_valid", 32'(instr_valid_o), 32'd0);

        // Fill to full with decoder stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 1'b0, 1'b0);
            chk("t2_cnt", 32'(count_o), 32'(i));
            chk("t2_stall", 32'(stall_o), (i == 3) ? 32'd1 : 32'd0);
            chk("t2_ready", 32'(fetch_ready_o), 32'd1);
            cyc();
        end
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        chk("t2_full_cnt", 32'(count_o), 32'd4);
        chk("t2_full_ready", 32'(fetch_ready_o), 32'd0);
        chk("t2_full_stall", 32'(stall_o), 32'd1);
        cyc();
        chk("t2_fifth_rejected", 32'(count_o), 32'd4);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_pop_pc0", instr_pc_o, 32'h10);
        chk("t2_ready_same_cycle", 32'(fetch_ready_o), 32'd0);
        cyc();
        chk("t2_ready_after_pop", 32'(fetch_ready_o), 32'd1);
        chk("t2_cnt_after_pop", 32'(count_o), 32'd3);
        chk("t2_pop_pc1", instr_pc_o, 32'h14);
        cyc();
        chk("t2_pop_pc2", instr_pc_o, 32'h18);
        cyc();
        chk("t2_pop_pc3", instr_pc_o, 32'h1C);
        cyc();
        chk("t2_drained_cnt", 32'(count_o), 32'd0);
        chk("t2_drained_valid", 32'(instr_valid_o), 32'd0);

        // Steady state at count 2 with push and pop every cycle; pointers wrap.
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        cyc();
        chk("t3_cnt_start", 32'(count_o), 32'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h208 + 32'(4 * i), 1'b0, 1'b1);
            chk("t3_cnt", 32'(count_o), 32'd2);
            chk("t3_pc", instr_pc_o, 32'h200 + 32'(4 * i));
            cyc();
        end
        chk("t3_cnt_end", 32'(count_o), 32'd2);
        chk("t3_pc_end", instr_pc_o, 32'h228);

        // Flush with count 3; wrong-path responses 0x40 and 0x44 must be dropped.
        drive(1'b1, 32'h230, 1'b0, 1'b0);
        cyc();
        chk("t4_cnt_pre", 32'(count_o), 32'd3);
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        chk("t4_valid_in_flush", 32'(instr_valid_o), 32'd0);
        cyc();
        drive(1'b1, 32'h44, 1'b0, 1'b1);
        chk("t4_cnt_post", 32'(count_o), 32'd0);
        chk("t4_valid_post", 32'(instr_valid_o), 32'd0);
        chk("t4_ready_drop", 32'(fetch_ready_o), 32'd1);
        cyc();
        drive(1'b1, 32'h100, 1'b0, 1'b1);
        chk("t4_cnt_dropped", 32'(count_o), 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4_cnt_new", 32'(count_o), 32'd1);
        chk("t4_valid_new", 32'(instr_valid_o), 32'd1);
        chk("t4_pc_new", instr_pc_o, 32'h100);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        chk("t4_cnt_drained", 32'(count_o), 32'd0);

        // Misalignment fault flag.
        drive(1'b1, 32'h102, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        chk("t5_pc_mis", instr_pc_o, 32'h102);
        chk("t5_fault_mis", 32'(instr_fault_o), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        chk("t5_pc_al", instr_pc_o, 32'h104);
        chk("t5_fault_al", 32'(instr_fault_o), 32'd0);
        cyc();
        chk("t5_cnt_drained", 32'(count_o), 32'd0);

        // Asynchronous reset mid-cycle with count 3.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_cnt_pre", 32'(count_o), 32'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_cnt_rst", 32'(count_o), 32'd0);
        chk("t6_valid_rst", 32'(instr_valid_o), 32'd0);
        chk("t6_ready_rst", 32'(fetch_ready_o), 32'd1);
        chk("t6_stall_rst", 32'(stall_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        chk("t6_cnt_after", 32'(count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
